baud_sipo_detect: RTL and testbench

- Bit-level datapath core of the UART pattern receiver.
- Contains three functions:
  - a baud tick generator with enable and re-align;
  - an 8-bit serial-in/parallel-out shift window;
  - a 4-bit pattern comparator that emits a one-cycle match pulse.
- A UART sampler FSM outside this block drives en/align and bit_valid/bit_in, and consumes tick.

---
 rtl/uart_pattern_pkg.sv | 18 +
 rtl/baud_sipo_detect_if.sv | 27 ++
 rtl/baud_tick_ctr.sv | 44 ++++
 rtl/baud_sipo_detect.sv | 88 ++++++++
 tb/tb_baud_sipo_detect.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pattern_pkg.sv
// Shared constants and helpers for the UART pattern receiver datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pattern_pkg;

  // Comparator width: one BCD digit
  localparam int PATTERN_W = 4;

  // Default system clock and serial bit rate
  localparam int DEF_CLK_FREQ_HZ = 1_600_000;
  localparam int DEF_BAUD_RATE   = 100_000;

  // Clock cycles per serial bit (integer division)
  function automatic int DIV_OF(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/baud_sipo_detect_if.sv
// Bundle of sampler-side strobes and datapath results for baud_sipo_detect.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a per-cycle level or strobe.
interface baud_sipo_detect_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             align;
  logic             tick;
  logic             bit_valid;
  logic             bit_in;
  logic [WIDTH-1:0] shift_window;
  logic             match_comb;
  logic             match_pulse;

  // Sampler FSM side: drives enables and sampled bits, consumes results
  modport master (
    output en, align, bit_valid, bit_in,
    input  tick, shift_window, match_comb, match_pulse
  );

  // Datapath side
  modport slave (
    input  en, align, bit_valid, bit_in,
    output tick, shift_window, match_comb, match_pulse
  );
endinterface

// File: rtl/baud_tick_ctr.sv
// Baud tick generator: free-running 0..DIV-1 counter with mid-bit re-align.
// Latency: first tick DIV/2 cycles after align, then every DIV cycles; tick is registered.
// Backpressure: none; en=0 parks the counter at zero and silences tick.
module baud_tick_ctr #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_align,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);
  // Loading DIV - DIV/2 puts the terminal count DIV/2 edges after the align edge
  localparam logic [CW-1:0] LOAD = CW'(DIV - DIV / 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Counter and registered tick; align wins over en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_align) begin
      r_cnt  <= LOAD;
      r_tick <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == TERM) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/baud_sipo_detect.sv
// Bit-level UART pattern datapath: baud ticks, WIDTH-bit SIPO window, 4-bit digit match.
// Latency: match_pulse 1 cycle after the shift edge (3 cycles with MATCH_SYNC_EN defined).
// Backpressure: none; bit_valid shifts unconditionally and all outputs are strobes/levels.
module baud_sipo_detect
  import uart_pattern_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
  parameter int BAUD_RATE     = DEF_BAUD_RATE,
  parameter int WIDTH         = 8,
  parameter int PATTERN_DIGIT = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  baud_sipo_detect_if.slave   bus
);

  localparam int DIV = DIV_OF(CLK_FREQ_HZ, BAUD_RATE);
  localparam logic [PATTERN_W-1:0] PAT = PATTERN_W'(PATTERN_DIGIT);

  if (DIV < 2) begin : g_div_chk
    $error("baud_sipo_detect: CLK_FREQ_HZ/BAUD_RATE must be >= 2");
  end
  if (WIDTH < PATTERN_W) begin : g_width_chk
    $error("baud_sipo_detect: WIDTH must be >= 4");
  end
  if (PATTERN_DIGIT < 0 || PATTERN_DIGIT > 9) begin : g_digit_chk
    $error("baud_sipo_detect: PATTERN_DIGIT must be 0..9");
  end

  baud_tick_ctr #(
    .DIV (DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (bus.en),
    .i_align (bus.align),
    .o_tick  (bus.tick)
  );

  logic [WIDTH-1:0]     r_window;
  logic [PATTERN_W-1:0] w_next_nib;
  logic                 r_hit;

  // Low nibble the window will hold after this edge if a bit is shifted in
  assign w_next_nib = {r_window[PATTERN_W-2:0], bus.bit_in};

  // SIPO window, newest bit at LSB; holds when no bit is offered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window <= '0;
    end else if (bus.bit_valid) begin
      r_window <= {r_window[WIDTH-2:0], bus.bit_in};
    end
  end

  // Match strobe judged on the post-shift window, so overlaps each fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= bus.bit_valid && (w_next_nib == PAT);
    end
  end

  assign bus.shift_window = r_window;
  assign bus.match_comb   = (r_window[PATTERN_W-1:0] == PAT);

`ifdef MATCH_SYNC_EN
  logic       r_tgl;
  logic [1:0] r_sync;

  // Toggle per strobe, then two-flop retime; edge of the toggle rebuilds the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgl  <= 1'b0;
      r_sync <= 2'b00;
    end else begin
      r_tgl  <= r_tgl ^ r_hit;
      r_sync <= {r_sync[0], r_tgl};
    end
  end

  assign bus.match_pulse = r_sync[1] ^ r_sync[0];
`else
  assign bus.match_pulse = r_hit;
`endif

endmodule

// File: tb/tb_baud_sipo_detect.sv
// Self-checking bench for baud_sipo_detect: behavioural model plus directed literals.
// Latency: model pulse delay follows MATCH_SYNC_EN (1 or 3 cycles).
// Backpressure: n/a.
module tb_baud_sipo_detect;

  localparam int WIDTH = 8;
  localparam int PAT   = 6;
  localparam int DIV   = 16;   // 1_600_000 / 100_000
`ifdef MATCH_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  baud_sipo_detect_if #(.WIDTH(WIDTH)) bus();

  baud_sipo_detect #(
    .CLK_FREQ_HZ   (1_600_000),
    .BAUD_RATE     (100_000),
    .WIDTH         (WIDTH),
    .PATTERN_DIGIT (PAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks    = 0;
  int failures  = 0;
  int e_cnt     = 0;
  int pulse_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, e_cnt);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit hist[$];        // every bit shifted in since the last reset
  bit hit_at[int];    // edge index -> the 4 newest bits equalled the digit
  int last_rst = 0;
  bit act      = 0;   // counter running since anchor
  int a_edge   = 0;
  int f_off    = 0;
  bit exp_tick;
  int exp_win;
  int mi;
  bit exp_pulse;

  function automatic int last_bits(input int k);
    int v = 0;
    for (int i = 0; i < k; i++)
      if (hist.size() > i) v = v | (int'(hist[hist.size() - 1 - i]) << i);
    return v;
  endfunction

  always @(posedge clk) begin
    e_cnt++;
    if (!rst_n) begin
      hist.delete();
      act      = 0;
      last_rst = e_cnt;
      exp_tick = 0;
    end else begin
      if (bus.align) begin
        act = 1; a_edge = e_cnt; f_off = DIV / 2; exp_tick = 0;
      end else if (!bus.en) begin
        act = 0; exp_tick = 0;
      end else begin
        if (!act) begin act = 1; a_edge = e_cnt; f_off = DIV - 1; end
        exp_tick = ((e_cnt - a_edge) >= f_off) && (((e_cnt - a_edge - f_off) % DIV) == 0);
      end
      if (bus.bit_valid) begin
        hist.push_back(bus.bit_in);
        hit_at[e_cnt] = (last_bits(4) == PAT);
      end
    end
    exp_win   = last_bits(WIDTH);
    mi        = e_cnt - (LAT - 1);
    exp_pulse = (mi > last_rst) && hit_at.exists(mi) && hit_at[mi];
    #1;
    chk("tick",         32'(bus.tick),         32'(exp_tick));
    chk("shift_window", 32'(bus.shift_window), 32'(exp_win));
    chk("match_comb",   32'(bus.match_comb),   32'((exp_win % 16) == PAT));
    chk("match_pulse",  32'(bus.match_pulse),  32'(exp_pulse));
    if (bus.match_pulse) pulse_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit en, input bit al, input bit bv, input bit bi);
    @(negedge clk);
    bus.en = en; bus.align = al; bus.bit_valid = bv; bus.bit_in = bi;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends bits[n-1] first, bits[0] last
  task automatic shift_bits(input logic [15:0] bits, input int n, input bit en);
    for (int i = n - 1; i >= 0; i--) cyc(en, 1'b0, 1'b1, bits[i]);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.en = 1'b0; bus.align = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int p0;

  initial begin
    bus.en = 1'b0; bus.align = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tick",   32'(bus.tick),         32'd0);
    chk("rst_window", 32'(bus.shift_window), 32'd0);
    chk("rst_pulse",  32'(bus.match_pulse),  32'd0);
    chk("rst_comb",   32'(bus.match_comb),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Baud phase: align at c=0, en off at 30..49, re-align at 50
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 60; c++) begin
      cyc(!(c >= 30 && c < 50), (c == 50), 1'b0, 1'b0);
      if (c == 7)  chk("tick_c7",  32'(bus.tick), 32'd0);
      if (c == 8)  chk("tick_c8",  32'(bus.tick), 32'd1);
      if (c == 24) chk("tick_c24", 32'(bus.tick), 32'd1);
      if (c == 40) chk("tick_c40", 32'(bus.tick), 32'd0);
      if (c == 57) chk("tick_c57", 32'(bus.tick), 32'd0);
      if (c == 58) chk("tick_c58", 32'(bus.tick), 32'd1);
    end
    idle(3);

    // Pattern hit
    p0 = pulse_cnt;
    shift_bits(16'b0110, 4, 1'b0);
    chk("hit_window", 32'(bus.shift_window), 32'h06);
    chk("hit_comb",   32'(bus.match_comb),   32'd1);
    idle(5);
    chk("hit_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Overlap, back-to-back shifts
    p0 = pulse_cnt;
    shift_bits(16'b0110110, 7, 1'b0);
    chk("ovl_window", 32'(bus.shift_window), 32'h36);
    idle(5);
    chk("ovl_pulses", 32'(pulse_cnt - p0), 32'd2);

    // Non-match and hold
    hold_reset();
    p0 = pulse_cnt;
    shift_bits(16'b1111, 4, 1'b0);
    idle(20);
    chk("hold_window", 32'(bus.shift_window), 32'h0F);
    chk("hold_comb",   32'(bus.match_comb),   32'd0);
    chk("hold_pulses", 32'(pulse_cnt - p0),   32'd0);

    // Reset mid-stream with the baud counter running
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    shift_bits(16'b011, 3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.en = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    #1;
    chk("mrst_window", 32'(bus.shift_window), 32'd0);
    chk("mrst_tick",   32'(bus.tick),         32'd0);
    chk("mrst_pulse",  32'(bus.match_pulse),  32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    shift_bits(16'b0110, 4, 1'b0);
    chk("post_window", 32'(bus.shift_window), 32'h06);
    idle(5);
    chk("post_pulses", 32'(pulse_cnt - p0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
